fcmp_pipe: RTL and testbench
============================

Name: fcmp_pipe

Overview:
- Pipelined, parametrised floating-point comparator for the FPU compare path (feq/flt/fle).
- Takes two IEEE-style operands of configurable exponent and mantissa width plus an opcode, and returns a 1-bit result.
- Valid/ready handshake on both sides so it can sit between the issue stage and the writeback arbiter with backpressure.
- Supersedes the single-function combinational "less-or-equal" compare.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, stored mantissa field width in bits (hidden bit not included).
- STAGES, 2, pipeline depth. Legal values are 1 or 2; any other value is a synthesis-time error.
- W, EXP_W+MAN_W+1, operand width. Derived; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode present.
- in_ready  out  1  block accepts an operand this cycle.
- op  in  2  opcode: 00 EQ, 01 LT, 10 LE, 11 reserved.
- x1  in  W  left operand.
- x2  in  W  right operand.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- result  out  1  compare outcome: x1 op x2.
- nv  out  1  invalid-operation flag (see Optional Feature).

Behaviour:
- Reset (rstn low, asynchronous): all stage valids clear; out_valid=0, result=0, nv=0. Any in-flight compares are discarded; no partial result appears after reset release.
- Field decode: s=x[W-1], e=x[W-2:MAN_W], m=x[MAN_W-1:0].
- Effective exponent: 1 when e==0, otherwise e.
- Effective mantissa: {0,m} when e==0, otherwise {1,m}.
  - Subnormals compare by magnitude correctly against normals.
- Magnitude ordering: compare effective exponent first, then effective mantissa. This yields mag_lt and mag_eq.
- Zero rule: a value is zero when {e,m}==0. Both operands zero means equal regardless of sign, so +0 == -0.
- Ordering rules:
  - Same sign, positive: x1<x2 iff mag_lt.
  - Same sign, negative: x1<x2 iff !mag_lt && !mag_eq.
  - Signs differ, not both zero: the negative operand is smaller.
- Equality: x1==x2 iff the bit patterns are equal, or both operands are zero.
- Results by opcode:
  - EQ = eq.
  - LT = lt.
  - LE = lt|eq.
  - op=11 gives result=0, and nv=0 unless NaN logic applies.
- Pipeline, STAGES=1: the decode-and-combine result is registered. Latency 1 cycle.
- Pipeline, STAGES=2:
  - Stage 1 registers: op, both signs, both zero flags, bitwise-equal flag, mag_lt, mag_eq, and NaN flags when enabled.
  - Stage 2 combines these into result/nv.
  - Latency 2 cycles.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Stage k advances when its successor is empty or the successor is advancing this cycle.
  - in_ready = !v1 || advance1. It is combinational from stage valids and out_ready; it has no dependence on in_valid.
  - Full throughput: one compare per cycle while out_ready=1.
- Backpressure: with out_ready=0 and every stage full, in_ready=0.
  - result, nv and all stage contents hold stable until the output is accepted.
  - out_valid, once asserted, does not drop without a transfer.
- Simultaneous input and output handshake in the same cycle when full: both transfers occur, with no bubble inserted.
- Ordering: results emerge strictly in input order. There is no reordering or dropping.
- out_valid=0: result and nv are don't-care, but the registers hold their last values.

Optional Feature:
- Macro: FCMP_NAN_EN.
- Defined:
  - NaN means e==all ones && m!=0.
  - Quiet NaN has MSB of m set; signalling NaN has it clear.
  - Any NaN operand forces result=0 for EQ, LT and LE.
  - nv=1 if LT or LE sees any NaN, or EQ sees a signalling NaN.
  - Flags are carried through the pipeline with the result.
- Undefined: no NaN decode. NaN patterns are ordered as ordinary magnitudes (exp all ones ranks largest) and nv is tied to 0.

Test Plan:
- Ordered basics, STAGES=2, out_ready=1:
  - LE(0x3F800000, 0x40000000) gives 1, and out_valid arrives exactly 2 cycles after acceptance.
  - LT(0x40000000, 0x3F800000) gives 0.
  - EQ(0x3F800000, 0x3F800000) gives 1.
- Signed zero and negatives:
  - EQ(0x00000000, 0x80000000) gives 1.
  - LT(0x80000000, 0x00000000) gives 0.
  - LT(0xBF800000, 0x3F800000) gives 1.
  - LE(0xC0000000, 0xBF800000) gives 1.
- Subnormal vs normal:
  - LT(0x00000001, 0x00800000) gives 1.
  - LT(0x007FFFFF, 0x00000001) gives 0.
  - LE(0x80000001, 0x00000000) gives 1.
- Backpressure:
  - Stream 4 back-to-back ops while holding out_ready=0 for 5 cycles: in_ready falls once both stages are full.
  - The held result stays stable.
  - After release, all 4 results appear in order with no loss or duplication.
- NaN with FCMP_NAN_EN defined:
  - EQ(0x7FC00000, 0x7FC00000) gives result=0, nv=0.
  - LT(0x7FC00000, 0x3F800000) gives result=0, nv=1.
  - EQ(0x7F800001, 0x3F800000) gives nv=1.
  - Undefined build: LT(0x3F800000, 0x7FC00000) gives 1, nv=0.
- Reset mid-flight and STAGES=1:
  - Assert rstn=0 with 2 ops in flight: out_valid clears immediately, and no stale result appears after release.
  - Rerun the first scenario with STAGES=1: latency 1 cycle, same results.

Source files
------------

// File: rtl/fcmp_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fcmp_pipe                                               |
// | Desc     : Pipelined floating-point comparator (EQ / LT / LE) with |
// |            valid/ready handshake on both sides. STAGES selects a   |
// |            1-cycle or 2-cycle pipeline.                            |
// | Options  : define FCMP_NAN_EN to decode NaNs and drive nv; left    |
// |            undefined, NaN patterns order as plain magnitudes.      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module fcmp_pipe #(
   parameter int EXP_W  = 8,
   parameter int MAN_W  = 23,
   parameter int STAGES = 2,
   parameter int W      = EXP_W + MAN_W + 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] x2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         result,
   output logic         nv
);

   localparam logic [1:0] C_OP_EQ = 2'b00;
   localparam logic [1:0] C_OP_LT = 2'b01;
   localparam logic [1:0] C_OP_LE = 2'b10;
   localparam int         C_MAG_W = EXP_W + MAN_W + 1;

   // Field decode. Magnitude key = {effective exponent, effective mantissa};
   // subnormals get exponent 1 and hidden bit 0 so they rank below normals.
   logic [EXP_W-1:0]   w_e1, w_e2;
   logic [MAN_W-1:0]   w_m1, w_m2;
   logic [C_MAG_W-1:0] w_mag1, w_mag2;
   logic               w_z1, w_z2, w_beq, w_mag_lt, w_mag_eq;
   logic               w_nan, w_snan;

   assign w_e1     = x1[W-2:MAN_W];
   assign w_e2     = x2[W-2:MAN_W];
   assign w_m1     = x1[MAN_W-1:0];
   assign w_m2     = x2[MAN_W-1:0];
   assign w_mag1   = {(w_e1 == '0) ? EXP_W'(1) : w_e1, |w_e1, w_m1};
   assign w_mag2   = {(w_e2 == '0) ? EXP_W'(1) : w_e2, |w_e2, w_m2};
   assign w_mag_lt = (w_mag1 < w_mag2);
   assign w_mag_eq = (w_mag1 == w_mag2);
   assign w_z1     = (x1[W-2:0] == '0);
   assign w_z2     = (x2[W-2:0] == '0);
   assign w_beq    = (x1 == x2);

`ifdef FCMP_NAN_EN
   logic w_nan1, w_nan2;
   assign w_nan1 = (&w_e1) & (|w_m1);
   assign w_nan2 = (&w_e2) & (|w_m2);
   assign w_nan  = w_nan1 | w_nan2;
   // Signalling NaN: mantissa MSB clear
   assign w_snan = (w_nan1 & ~w_m1[MAN_W-1]) | (w_nan2 & ~w_m2[MAN_W-1]);
`else
   assign w_nan  = 1'b0;
   assign w_snan = 1'b0;
`endif

   // Combine decoded flags into {result, nv}
   function automatic logic [1:0] f_combine(
      input logic [1:0] f_op,
      input logic       s1, s2, z1, z2, beq, mlt, meq, nan, snan
   );
      logic lt, eq, r, v;
      eq = beq | (z1 & z2);
      if (z1 & z2)       lt = 1'b0;
      else if (s1 != s2) lt = s1;
      else if (!s1)      lt = mlt;
      else               lt = !mlt && !meq;
      case (f_op)
         C_OP_EQ: begin r = eq;      v = snan; end
         C_OP_LT: begin r = lt;      v = nan;  end
         C_OP_LE: begin r = lt | eq; v = nan;  end
         default: begin r = 1'b0;    v = 1'b0; end
      endcase
      if (nan) r = 1'b0;
      return {r, v};
   endfunction

   logic out_valid_q, result_q, nv_q;

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign nv        = nv_q;

   generate
      if ((STAGES != 1 && STAGES != 2) || (W != EXP_W + MAN_W + 1)) begin : g_bad_cfg
         $error("fcmp_pipe: STAGES must be 1 or 2 and W must equal EXP_W+MAN_W+1");
      end

      if (STAGES == 1) begin : g_one_stage
         logic [1:0] w_cmp_d;
         assign w_cmp_d  = f_combine(op, x1[W-1], x2[W-1], w_z1, w_z2, w_beq,
                                     w_mag_lt, w_mag_eq, w_nan, w_snan);
         assign in_ready = !out_valid_q || out_ready;

         // Output register: refill whenever the slot is empty or draining
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               out_valid_q <= 1'b0;
               result_q    <= 1'b0;
               nv_q        <= 1'b0;
            end else if (in_ready) begin
               out_valid_q <= in_valid;
               if (in_valid) begin
                  result_q <= w_cmp_d[1];
                  nv_q     <= w_cmp_d[0];
               end
            end
         end
      end else begin : g_two_stage
         logic       s1_valid_q;
         logic [1:0] s1_op_q;
         logic       s1_sign1_q, s1_sign2_q, s1_zero1_q, s1_zero2_q;
         logic       s1_beq_q, s1_mag_lt_q, s1_mag_eq_q, s1_nan_q, s1_snan_q;
         logic       w_adv1;
         logic [1:0] w_cmp_d;

         assign w_adv1   = !out_valid_q || out_ready;
         assign in_ready = !s1_valid_q || w_adv1;
         assign w_cmp_d  = f_combine(s1_op_q, s1_sign1_q, s1_sign2_q, s1_zero1_q,
                                     s1_zero2_q, s1_beq_q, s1_mag_lt_q,
                                     s1_mag_eq_q, s1_nan_q, s1_snan_q);

         // Stage 1: capture decoded flags when the stage can move
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               s1_valid_q  <= 1'b0;
               s1_op_q     <= 2'b00;
               s1_sign1_q  <= 1'b0;
               s1_sign2_q  <= 1'b0;
               s1_zero1_q  <= 1'b0;
               s1_zero2_q  <= 1'b0;
               s1_beq_q    <= 1'b0;
               s1_mag_lt_q <= 1'b0;
               s1_mag_eq_q <= 1'b0;
               s1_nan_q    <= 1'b0;
               s1_snan_q   <= 1'b0;
            end else if (in_ready) begin
               s1_valid_q <= in_valid;
               if (in_valid) begin
                  s1_op_q     <= op;
                  s1_sign1_q  <= x1[W-1];
                  s1_sign2_q  <= x2[W-1];
                  s1_zero1_q  <= w_z1;
                  s1_zero2_q  <= w_z2;
                  s1_beq_q    <= w_beq;
                  s1_mag_lt_q <= w_mag_lt;
                  s1_mag_eq_q <= w_mag_eq;
                  s1_nan_q    <= w_nan;
                  s1_snan_q   <= w_snan;
               end
            end
         end

         // Stage 2: combine flags into the registered result
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               out_valid_q <= 1'b0;
               result_q    <= 1'b0;
               nv_q        <= 1'b0;
            end else if (w_adv1) begin
               out_valid_q <= s1_valid_q;
               if (s1_valid_q) begin
                  result_q <= w_cmp_d[1];
                  nv_q     <= w_cmp_d[0];
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fcmp_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_fcmp_pipe                                            |
// | Desc     : Self-checking bench for fcmp_pipe; instance 0 uses      |
// |            STAGES=2, instance 1 uses STAGES=1. Honours FCMP_NAN_EN.|
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_fcmp_pipe;

   typedef struct packed {
      logic r;
      logic nv;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic        iv   [2];
   logic [1:0]  opv  [2];
   logic [31:0] a    [2];
   logic [31:0] b    [2];
   logic        ordy [2];
   wire         ir   [2];
   wire         ov   [2];
   wire         res  [2];
   wire         nvv  [2];

   int   stg   [2] = '{2, 1};
   int   nin   [2] = '{0, 0};
   int   nout  [2] = '{0, 0};
   int   ndrop [2] = '{0, 0};
   bit   stall [2] = '{0, 0};
   exp_t q0 [$];
   exp_t q1 [$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]  t_op [10] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
   logic [31:0] t_a  [10] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h00000000,
                              32'h80000000, 32'hBF800000, 32'hC0000000, 32'h00000001,
                              32'h007FFFFF, 32'h80000001};
   logic [31:0] t_b  [10] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                              32'h00000000, 32'h3F800000, 32'hBF800000, 32'h00800000,
                              32'h00000001, 32'h00000000};
   logic        t_r  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2)) u_dut2 (
      .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
      .x1(a[0]), .x2(b[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .result(res[0]), .nv(nvv[0]));

   fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
      .x1(a[1]), .x2(b[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .result(res[1]), .nv(nvv[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Reference: a float orders like the signed integer +/-(magnitude bits),
   // with both zeros mapping to 0.
`ifdef FCMP_NAN_EN
   function automatic bit is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction
`endif

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] p, input logic [31:0] q);
      exp_t   e;
      longint kp, kq;
      bit     eq, lt, nan_any, snan_any;
      kp = p[31] ? -longint'({1'b0, p[30:0]}) : longint'({1'b0, p[30:0]});
      kq = q[31] ? -longint'({1'b0, q[30:0]}) : longint'({1'b0, q[30:0]});
      eq = (kp == kq);
      lt = (kp < kq);
      nan_any  = 1'b0;
      snan_any = 1'b0;
`ifdef FCMP_NAN_EN
      nan_any  = is_nan(p) || is_nan(q);
      snan_any = (is_nan(p) && !p[22]) || (is_nan(q) && !q[22]);
`endif
      case (o)
         2'd0:    e.r = eq;
         2'd1:    e.r = lt;
         2'd2:    e.r = lt || eq;
         default: e.r = 1'b0;
      endcase
      e.nv = (o == 2'd0) ? snan_any : (o == 2'd3) ? 1'b0 : nan_any;
      if (nan_any) e.r = 1'b0;
      return e;
   endfunction

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   // Scoreboard monitor, sampled 1 ns before each rising edge
   task automatic mon(input int k);
      exp_t e;
      if (!rstn) begin
         stall[k] = 1'b0;
         return;
      end
      if (stall[k]) chk("valid_hold", ov[k], 1);
      if (ov[k]) begin
         chk("output_expected", qsize(k) != 0, 1);
         if (qsize(k) != 0) begin
            e = (k == 0) ? q0[0] : q1[0];
            chk("sb_result", res[k], e.r);
            chk("sb_nv", nvv[k], e.nv);
            if (ordy[k]) begin
               if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
               nout[k]++;
            end
         end
      end
      stall[k] = ov[k] && !ordy[k];
      if (iv[k] && ir[k]) begin
         e = model(opv[k], a[k], b[k]);
         if (k == 0) q0.push_back(e); else q1.push_back(e);
         nin[k]++;
      end
   endtask

   always @(negedge clk) begin
      #4;
      for (int k = 0; k < 2; k++) mon(k);
   end

   task automatic send(input int k, input logic [1:0] o, input logic [31:0] p, input logic [31:0] q);
      int guard = 0;
      @(negedge clk);
      iv[k] = 1'b1; opv[k] = o; a[k] = p; b[k] = q;
      #1;
      while (!ir[k] && guard < 100) begin
         @(negedge clk); #1; guard++;
      end
      if (guard >= 100) chk("send_timeout", guard, 0);
      @(posedge clk);
   endtask

   task automatic one_op(input int k, input logic [1:0] o, input logic [31:0] p,
                         input logic [31:0] q, input logic er, input logic en);
      int lat;
      @(negedge clk);
      iv[k] = 1'b1; opv[k] = o; a[k] = p; b[k] = q;
      #1;
      chk("idle_in_ready", ir[k], 1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      iv[k] = 1'b0;
      while (!ov[k] && lat < 10) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      chk("latency", lat, stg[k]);
      chk("dir_result", res[k], er);
      chk("dir_nv", nvv[k], en);
   endtask

   task automatic drain(input int k);
      int g = 0;
      while ((qsize(k) != 0 || ov[k]) && g < 200) begin
         @(negedge clk); #5; g++;
      end
      chk("drain_done", g < 200, 1);
   endtask

   function automatic logic [31:0] rnd_operand();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0:       return {r[31], 31'd0};
         1:       return {r[31], 8'h00, r[22:0]};
         2:       return {r[31], 8'h7F, r[22:0]};
         3:       return {r[31], 8'hFF, r[22:0]};
         4:       return {r[31], 8'h01, r[22:0]};
         default: return r;
      endcase
   endfunction

   task automatic rand_phase(input int k, input int n);
      bit done = 1'b0;
      fork
         begin
            for (int i = 0; i < n; i++) begin
               logic [31:0] p, q;
               logic [1:0]  o;
               p = rnd_operand();
               case ($urandom_range(0, 3))
                  0:       q = p;
                  1:       q = p ^ 32'h8000_0000;
                  default: q = rnd_operand();
               endcase
               o = 2'($urandom_range(0, 3));
               send(k, o, p, q);
            end
            @(negedge clk);
            iv[k] = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               ordy[k] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      ordy[k] = 1'b1;
      drain(k);
   endtask

   initial begin
      rstn = 1'b0;
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; opv[k] = 2'd0; a[k] = 32'd0; b[k] = 32'd0; ordy[k] = 1'b1;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_out_valid", ov[k], 0);
         chk("reset_result", res[k], 0);
         chk("reset_nv", nvv[k], 0);
         chk("reset_in_ready", ir[k], 1);
      end
      @(negedge clk);
      rstn = 1'b1;

      // Directed ordered / signed-zero / subnormal cases on both depths
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 10; i++) one_op(k, t_op[i], t_a[i], t_b[i], t_r[i], 1'b0);
`ifdef FCMP_NAN_EN
         one_op(k, 2'd0, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0);
         one_op(k, 2'd1, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1);
         one_op(k, 2'd0, 32'h7F800001, 32'h3F800000, 1'b0, 1'b1);
`else
         one_op(k, 2'd1, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0);
`endif
      end

      // Backpressure on the 2-stage instance
      @(negedge clk);
      ordy[0] = 1'b0;
      send(0, 2'd2, 32'h3F800000, 32'h40000000);
      send(0, 2'd1, 32'h40000000, 32'h3F800000);
      @(negedge clk);
      iv[0] = 1'b1; opv[0] = 2'd0; a[0] = 32'h3F800000; b[0] = 32'h3F800000;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("bp_in_ready_low", ir[0], 0);
         chk("bp_out_valid", ov[0], 1);
         chk("bp_hold_result", res[0], 1);
         @(negedge clk);
      end
      ordy[0] = 1'b1;
      #1;
      chk("bp_release_in_ready", ir[0], 1);
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      #1;
      chk("bp_no_bubble", ov[0], 1);
      send(0, 2'd1, 32'hBF800000, 32'h3F800000);
      @(negedge clk);
      iv[0] = 1'b0;
      drain(0);

      // Reset with two compares in flight
      @(negedge clk);
      ordy[0] = 1'b0;
      send(0, 2'd2, 32'h3F800000, 32'h40000000);
      send(0, 2'd0, 32'h3F800000, 32'h3F800000);
      @(negedge clk);
      iv[0] = 1'b0;
      #1;
      rstn = 1'b0;
      #1;
      chk("midrst_out_valid", ov[0], 0);
      chk("midrst_result", res[0], 0);
      chk("midrst_nv", nvv[0], 0);
      ndrop[0] += q0.size();
      q0.delete();
      @(negedge clk);
      rstn = 1'b1;
      ordy[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         chk("no_stale_output", ov[0], 0);
      end

      // Randomized traffic with random backpressure on both depths
      rand_phase(0, 120);
      rand_phase(1, 120);

      for (int k = 0; k < 2; k++) begin
         chk("scoreboard_empty", qsize(k), 0);
         chk("in_out_count", nout[k] + ndrop[k], nin[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
